mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/arb_starve_ctr.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the CPU/DMA memory port arbiter: FSM states, owner ids, counter width.
package mem_arb_pkg;

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnerCpu = 1'b0,
    OwnerDma = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Grant selection between CPU and DMA with a saturating DMA starvation counter.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   idle,
  input  logic   cpu_req,
  input  logic   dma_req,
  output logic   grant,
  output owner_e grant_owner
);

  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    grant       = idle & (cpu_req | dma_req);
    // CPU has priority unless DMA has already waited out STARVE_MAX CPU grants.
    grant_owner = (dma_req && (!cpu_req || cnt_q == StarveMax)) ? OwnerDma : OwnerCpu;
    cnt_d       = cnt_q;
    if (idle) begin
      if (!dma_req || grant_owner == OwnerDma) begin
        cnt_d = '0;
      end else if (cnt_q != StarveMax) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: serves one CPU or DMA access at a time, IDLE -> BUSY -> RESP.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [CntW-1:0] LatInit = CntW'(MEM_LAT - 1);

  arb_state_e      state_q;
  owner_e          owner_q;
  logic            we_q;
  logic [31:0]     addr_q, wdata_q;
  logic [CntW-1:0] lat_cnt_q;
  logic [31:0]     cpu_rdata_q, dma_rdata_q;
  logic            cpu_ready_q, dma_ready_q, mem_en_q, mem_we_q;

  logic        grant;
  owner_e      grant_owner;
  logic        win_we;
  logic [31:0] win_addr, win_wdata;

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk        (clk),
    .reset      (reset),
    .idle       (state_q == StIdle),
    .cpu_req    (cpu_req),
    .dma_req    (dma_req),
    .grant      (grant),
    .grant_owner(grant_owner)
  );

  always_comb begin
    win_we    = cpu_we;
    win_addr  = cpu_addr;
    win_wdata = cpu_wdata;
    if (grant_owner == OwnerDma) begin
      win_we    = dma_we;
      win_addr  = dma_addr;
      win_wdata = dma_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= OwnerCpu;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_cnt_q   <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (grant) begin
            owner_q   <= grant_owner;
            we_q      <= win_we;
            addr_q    <= win_addr;
            wdata_q   <= win_wdata;
            lat_cnt_q <= LatInit;
            mem_en_q  <= 1'b1;
            mem_we_q  <= win_we;
            state_q   <= StBusy;
          end
        end
        StBusy: begin
          if (lat_cnt_q == '0) begin
            if (!we_q) begin
              if (owner_q == OwnerCpu) cpu_rdata_q <= mem_rdata;
              else                     dma_rdata_q <= mem_rdata;
            end
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            cpu_ready_q <= (owner_q == OwnerCpu);
            dma_ready_q <= (owner_q == OwnerDma);
            state_q     <= StResp;
          end else begin
            lat_cnt_q <= lat_cnt_q - CntW'(1);
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign dma_ready = dma_ready_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
